// File: rtl/clint_pkg.sv
// clint_pkg: offsets, types and address helpers shared by the CLINT.
// Offsets are 16-bit byte offsets relative to the block base address.
package clint_pkg;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [31:0] SPAN_LAST = 32'h0000_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } clint_state_t;

  typedef logic [63:0] UInt64;

  // Inclusive unsigned range check.
  function automatic logic x_in_range(
    input logic [31:0] x,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (x >= lo) && (x <= hi);
  endfunction

  // Word alignment: only the two low address bits matter.
  function automatic logic ialigned(
    input logic [1:0] a
  );
    return a == 2'b00;
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// clint_tick_gen: mtime tick source. Optional prescaler (CLINT_PRESCALER_EN).
// Ports: clk, reset (async, active-high), clear (restart count), tick (out).
module clint_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

`ifdef CLINT_PRESCALER_EN

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] count;

  // The tick is asserted on the cycle whose edge wraps the count to 0.
  assign tick = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

`else

  logic unused_ok;

  assign unused_ok = &{1'b0, clk, reset, clear};
  assign tick      = 1'b1;

`endif

endmodule

// File: rtl/mmio_clint.sv
// mmio_clint: CLINT responder (msip, mtimecmp, mtime) with valid/ready MMIO.
// Ports: clk, reset, req_* / resp_* handshakes, mtip, msip. Macro CLINT_PRESCALER_EN.
module mmio_clint
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE           = 32'h0200_0000,
  parameter UInt64       RESET_MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned TICK_DIV       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mtip,
  output logic        msip
);

  localparam logic [31:0] LAST = BASE + SPAN_LAST;

  clint_state_t state;

  UInt64 mtime;
  UInt64 mtimecmp;
  logic  msip_q;

  logic [15:0] off;
  logic        in_rng;
  logic        aligned;
  logic        ok;
  logic        sel_msip;
  logic        sel_cmp_lo;
  logic        sel_cmp_hi;
  logic        sel_time_lo;
  logic        sel_time_hi;
  logic        err;
  logic [31:0] rd;

  logic accept;
  logic wr;
  logic we_msip;
  logic we_cmp_lo;
  logic we_cmp_hi;
  logic we_time_lo;
  logic we_time_hi;
  logic tick;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign msip       = msip_q;

  assign accept = req_valid && req_ready;
  assign wr     = accept && req_wen;

  // Only the low 16 offset bits select a register; the range check
  // covers the rest of the address.
  always_comb begin
    off         = req_addr[15:0] - BASE[15:0];
    in_rng      = x_in_range(req_addr, BASE, LAST);
    aligned     = ialigned(req_addr[1:0]);
    ok          = in_rng && aligned;
    sel_msip    = ok && (off == MSIP_OFF);
    sel_cmp_lo  = ok && (off == MTIMECMP_LO_OFF);
    sel_cmp_hi  = ok && (off == MTIMECMP_HI_OFF);
    sel_time_lo = ok && (off == MTIME_LO_OFF);
    sel_time_hi = ok && (off == MTIME_HI_OFF);
    err         = !(sel_msip || sel_cmp_lo || sel_cmp_hi ||
                    sel_time_lo || sel_time_hi);
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      sel_msip:    rd = {31'd0, msip_q};
      sel_cmp_lo:  rd = mtimecmp[31:0];
      sel_cmp_hi:  rd = mtimecmp[63:32];
      sel_time_lo: rd = mtime[31:0];
      sel_time_hi: rd = mtime[63:32];
      default:     rd = '0;
    endcase
  end

  assign we_msip    = wr && sel_msip;
  assign we_cmp_lo  = wr && sel_cmp_lo;
  assign we_cmp_hi  = wr && sel_cmp_hi;
  assign we_time_lo = wr && sel_time_lo;
  assign we_time_hi = wr && sel_time_hi;

  clint_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(we_time_lo || we_time_hi),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msip_q   <= 1'b0;
      mtimecmp <= RESET_MTIMECMP;
    end else begin
      if (we_msip) begin
        msip_q <= req_wdata[0];
      end
      if (we_cmp_lo) begin
        mtimecmp[31:0] <= req_wdata;
      end
      if (we_cmp_hi) begin
        mtimecmp[63:32] <= req_wdata;
      end
    end
  end

  // A half write wins over the tick; the other half is left as it was,
  // with no carry between halves on that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime <= '0;
    end else if (we_time_lo) begin
      mtime <= {mtime[63:32], req_wdata};
    end else if (we_time_hi) begin
      mtime <= {req_wdata, mtime[31:0]};
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // Registered compare on pre-edge values: one cycle of lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtip <= 1'b0;
    end else begin
      mtip <= (mtime >= mtimecmp);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state      <= RESP;
            resp_rdata <= (err || req_wen) ? 32'd0 : rd;
            resp_error <= err;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_rdata <= '0;
            resp_error <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
